// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard unit for the five-stage pipeline. It keeps a registered shadow copy
// of every in-flight producer (destination, remaining Tnew, source addresses)
// for the stages after D. From that copy it works out the D-stage stall and
// the forwarding selects for the consumers in D, E and M. It can also track
// the multi-cycle multiply/divide unit, so that HI/LO users wait while the
// unit is busy.
//
// Optional feature macro: HAZARD_MD_EN
//   defined   -> mult/div busy counter, md_op/md_div slot fields and the
//                mult/div stall term are built in.
//   undefined -> d_md_op, d_md_div and d_md_use are ignored, md_busy is 0,
//                and stall has only the data-hazard term.
//
// Parameters:
//   NSRC      source operands per instruction
//   DEPTH     shadow stages after D (1=E, 2=M, 3=W), at least 3
//   TW        width of the Tnew/Tuse fields
//   MULT_LAT  busy cycles for a multiply
//   DIV_LAT   busy cycles for a divide
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   d_valid    D holds a real instruction
//   d_src      packed source addresses, NSRC x 5 bits, 0 = unused
//   d_tuse     packed per-source Tuse, NSRC x TW bits, counted from D
//   d_dst      destination register, 0 = none
//   d_tnew     cycles until the result can be forwarded, counted from E entry
//   d_md_op    instruction starts a mult/div
//   d_md_div   1 = divide, 0 = multiply (qualified by d_md_op)
//   d_md_use   instruction touches HI/LO or starts a mult/div
//   stall      freeze PC and F/D, insert a bubble into E
//   fwd_d_sel  per-source producer stage for the D consumer, 0 = register file
//   fwd_e_sel  per-source producer stage for the E consumer
//   fwd_m_sel  per-source producer stage for the M consumer
//   md_busy    mult/div unit busy
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int NSRC     = 2,
  parameter int DEPTH    = 3,
  parameter int TW       = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  localparam int SW      = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               d_valid,
  input  logic [NSRC*5-1:0]  d_src,
  input  logic [NSRC*TW-1:0] d_tuse,
  input  logic [4:0]         d_dst,
  input  logic [TW-1:0]      d_tnew,
  input  logic               d_md_op,
  input  logic               d_md_div,
  input  logic               d_md_use,
  output logic               stall,
  output logic [NSRC*SW-1:0] fwd_d_sel,
  output logic [NSRC*SW-1:0] fwd_e_sel,
  output logic [NSRC*SW-1:0] fwd_m_sel,
  output logic               md_busy
);

  // Shadow pipeline, slot 1 = E, slot 2 = M, slot 3 = W.
  logic [4:0]    slot_dst  [1:DEPTH];
  logic [TW-1:0] slot_tnew [1:DEPTH];
  logic [4:0]    slot_src  [1:DEPTH][NSRC];

  logic data_haz;
  logic md_haz;
  logic issue;

  assign issue = d_valid && !stall;

  // Nearest producer of addr among slots first..DEPTH. Scanning from the
  // oldest slot towards the newest lets the nearest match overwrite older
  // ones. idx = 0 means no producer is in flight.
  function automatic void scan(input  logic [4:0]    addr,
                               input  int            first,
                               output logic [SW-1:0] idx,
                               output logic [TW-1:0] tnew);
    idx  = '0;
    tnew = '0;
    for (int j = DEPTH; j >= 1; j--) begin
      if ((j >= first) && (addr != 5'd0) && (slot_dst[j] == addr)) begin
        idx  = SW'(j);
        tnew = slot_tnew[j];
      end
    end
  endfunction

  // A nearest match that is still computing (tnew > 0) blocks older
  // matches. The select falls back to 0, and for D the hazard comes from
  // comparing that tnew with the consumer's Tuse.
  always_comb begin : hazard_comb
    logic [SW-1:0] idx;
    logic [TW-1:0] tn;
    idx       = '0;
    tn        = '0;
    data_haz  = 1'b0;
    fwd_d_sel = '0;
    fwd_e_sel = '0;
    fwd_m_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      scan(d_src[i*5 +: 5], 1, idx, tn);
      if (d_valid && (idx != '0) && (tn > d_tuse[i*TW +: TW]))
        data_haz = 1'b1;
      if ((idx != '0) && (tn == '0))
        fwd_d_sel[i*SW +: SW] = idx;

      scan(slot_src[1][i], 2, idx, tn);
      if ((idx != '0) && (tn == '0))
        fwd_e_sel[i*SW +: SW] = idx;

      scan(slot_src[2][i], 3, idx, tn);
      if ((idx != '0) && (tn == '0))
        fwd_m_sel[i*SW +: SW] = idx;
    end
  end

  assign stall = data_haz | md_haz;

  // Shadow advance: every slot moves one stage older and its tnew counts
  // down to 0, then stays there. Slot 1 takes the D instruction only when
  // it actually issues. Otherwise it takes an all-zero bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 1; j <= DEPTH; j++) begin
        slot_dst[j]  <= '0;
        slot_tnew[j] <= '0;
        for (int i = 0; i < NSRC; i++)
          slot_src[j][i] <= '0;
      end
    end else begin
      for (int j = DEPTH; j >= 2; j--) begin
        slot_dst[j]  <= slot_dst[j-1];
        slot_tnew[j] <= (slot_tnew[j-1] != '0) ? slot_tnew[j-1] - TW'(1) : '0;
        for (int i = 0; i < NSRC; i++)
          slot_src[j][i] <= slot_src[j-1][i];
      end
      if (issue) begin
        slot_dst[1]  <= d_dst;
        slot_tnew[1] <= d_tnew;
        for (int i = 0; i < NSRC; i++)
          slot_src[1][i] <= d_src[i*5 +: 5];
      end else begin
        slot_dst[1]  <= '0;
        slot_tnew[1] <= '0;
        for (int i = 0; i < NSRC; i++)
          slot_src[1][i] <= '0;
      end
    end
  end

`ifdef HAZARD_MD_EN
  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  logic          slot_md_op  [1:DEPTH];
  logic          slot_md_div [1:DEPTH];
  logic [CW-1:0] md_cnt;

  // The mult/div tags travel with the rest of the slot, so they need the
  // same issue/bubble handling as the main shadow fields.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 1; j <= DEPTH; j++) begin
        slot_md_op[j]  <= 1'b0;
        slot_md_div[j] <= 1'b0;
      end
    end else begin
      for (int j = DEPTH; j >= 2; j--) begin
        slot_md_op[j]  <= slot_md_op[j-1];
        slot_md_div[j] <= slot_md_div[j-1];
      end
      slot_md_op[1]  <= issue && d_md_op;
      slot_md_div[1] <= issue && d_md_div;
    end
  end

  // The unit starts when the mult/div reaches E. The counter ignores stall,
  // so a waiting HI/LO user is released in the first cycle it reads 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      md_cnt <= '0;
    else if (slot_md_op[1])
      md_cnt <= slot_md_div[1] ? CW'(DIV_LAT) : CW'(MULT_LAT);
    else if (md_cnt != '0)
      md_cnt <= md_cnt - CW'(1);
  end

  assign md_busy = (md_cnt != '0);
  // A mult/div sitting in E has not loaded the counter yet, but it already
  // owns HI/LO.
  assign md_haz  = d_valid && d_md_use && (slot_md_op[1] || md_busy);
`else
  assign md_busy = 1'b0;
  assign md_haz  = 1'b0;

  wire unused_md_inputs = &{1'b0, d_md_op, d_md_div, d_md_use,
                            ((MULT_LAT + DIV_LAT) > 0)};
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Testbench for hazard_scoreboard. A reference model treats the pipeline as
// a queue of issued instructions ordered by age. A producer's remaining Tnew
// is its issue Tnew minus its age. The mult/div unit is tracked as the last
// cycle in which it is busy. A compare process checks every DUT output
// against the model on each falling edge. Directed scenarios add
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;
  localparam int NSRC     = 2;
  localparam int DEPTH    = 3;
  localparam int TW       = 2;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;
  localparam int SW       = $clog2(DEPTH + 1);
`ifdef HAZARD_MD_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               d_valid = 1'b0;
  logic [NSRC*5-1:0]  d_src = '0;
  logic [NSRC*TW-1:0] d_tuse = '0;
  logic [4:0]         d_dst = '0;
  logic [TW-1:0]      d_tnew = '0;
  logic               d_md_op = 1'b0;
  logic               d_md_div = 1'b0;
  logic               d_md_use = 1'b0;
  logic               stall;
  logic [NSRC*SW-1:0] fwd_d_sel;
  logic [NSRC*SW-1:0] fwd_e_sel;
  logic [NSRC*SW-1:0] fwd_m_sel;
  logic               md_busy;

  int checks = 0;
  int passes = 0;

  hazard_scoreboard #(
    .NSRC(NSRC), .DEPTH(DEPTH), .TW(TW), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .d_valid(d_valid), .d_src(d_src),
    .d_tuse(d_tuse), .d_dst(d_dst), .d_tnew(d_tnew), .d_md_op(d_md_op),
    .d_md_div(d_md_div), .d_md_use(d_md_use), .stall(stall),
    .fwd_d_sel(fwd_d_sel), .fwd_e_sel(fwd_e_sel), .fwd_m_sel(fwd_m_sel),
    .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  // Reference model state. The front of the queue is the instruction in E.
  typedef struct packed {
    logic [4:0]        dst;
    logic [TW-1:0]     tnew;
    logic [NSRC*5-1:0] src;
    logic              md;
    logic              div;
  } ent_t;

  ent_t pipe[$];
  int   cyc      = 0;
  int   busy_end = -1;

  function automatic void lookup(input logic [4:0] a, input int from,
                                 output int sel, output int rem);
    ent_t e;
    sel = 0;
    rem = 0;
    if (a != 5'd0) begin
      for (int k = from; k < pipe.size(); k++) begin
        e = pipe[k];
        if (e.dst == a) begin
          sel = k + 1;
          rem = (int'(e.tnew) > k) ? int'(e.tnew) - k : 0;
          break;
        end
      end
    end
  endfunction

  function automatic void model_outputs(output bit st, output bit busy,
                                        output logic [NSRC*SW-1:0] fd,
                                        output logic [NSRC*SW-1:0] fe,
                                        output logic [NSRC*SW-1:0] fm);
    int   sel, rem;
    bit   md_in_e;
    ent_t e;
    st = 1'b0;
    fd = '0;
    fe = '0;
    fm = '0;
    busy    = MD_EN && (busy_end >= cyc);
    md_in_e = 1'b0;
    if (pipe.size() > 0) begin
      e = pipe[0];
      md_in_e = MD_EN && e.md;
    end
    for (int i = 0; i < NSRC; i++) begin
      lookup(d_src[i*5 +: 5], 0, sel, rem);
      if (d_valid && sel != 0 && rem > int'(d_tuse[i*TW +: TW])) st = 1'b1;
      if (sel != 0 && rem == 0) fd[i*SW +: SW] = SW'(sel);
      if (pipe.size() > 0) begin
        e = pipe[0];
        lookup(e.src[i*5 +: 5], 1, sel, rem);
        if (sel != 0 && rem == 0) fe[i*SW +: SW] = SW'(sel);
      end
      if (pipe.size() > 1) begin
        e = pipe[1];
        lookup(e.src[i*5 +: 5], 2, sel, rem);
        if (sel != 0 && rem == 0) fm[i*SW +: SW] = SW'(sel);
      end
    end
    if (d_valid && d_md_use && (md_in_e || busy)) st = 1'b1;
  endfunction

  // Model update at each clock edge. It uses the model's own stall to
  // decide whether D issues.
  bit                 u_stall, u_busy;
  logic [NSRC*SW-1:0] u_d, u_e, u_m;
  ent_t               new_ent, head;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe.delete();
      busy_end = -1;
      cyc = 0;
    end else begin
      model_outputs(u_stall, u_busy, u_d, u_e, u_m);
      if (pipe.size() > 0) begin
        head = pipe[0];
        if (MD_EN && head.md)
          busy_end = cyc + (head.div ? DIV_LAT : MULT_LAT);
      end
      new_ent = '0;
      if (d_valid && !u_stall) begin
        new_ent.dst  = d_dst;
        new_ent.tnew = d_tnew;
        new_ent.src  = d_src;
        new_ent.md   = d_md_op;
        new_ent.div  = d_md_div;
      end
      pipe.push_front(new_ent);
      if (pipe.size() > DEPTH) void'(pipe.pop_back());
      cyc++;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic int selOf(input logic [NSRC*SW-1:0] v, input int i);
    return int'(v[i*SW +: SW]);
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  bit                 m_stall, m_busy;
  logic [NSRC*SW-1:0] m_d, m_e, m_m;
  always @(negedge clk) begin
    model_outputs(m_stall, m_busy, m_d, m_e, m_m);
    checkOutput($sformatf("cycle %0d stall", cyc), int'(stall), int'(m_stall));
    checkOutput($sformatf("cycle %0d md_busy", cyc), int'(md_busy), int'(m_busy));
    checkOutput($sformatf("cycle %0d fwd_d_sel", cyc), int'(fwd_d_sel), int'(m_d));
    checkOutput($sformatf("cycle %0d fwd_e_sel", cyc), int'(fwd_e_sel), int'(m_e));
    checkOutput($sformatf("cycle %0d fwd_m_sel", cyc), int'(fwd_m_sel), int'(m_m));
  end

  // Drive one D instruction just after the clock edge, then settle.
  task automatic applyStimulus(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                               input logic [TW-1:0] u0, input logic [TW-1:0] u1,
                               input logic [4:0] dst, input logic [TW-1:0] tn,
                               input logic mop, input logic mdiv, input logic muse);
    @(posedge clk);
    #1;
    d_valid  = v;
    d_src    = {s1, s0};
    d_tuse   = {u1, u0};
    d_dst    = dst;
    d_tnew   = tn;
    d_md_op  = mop;
    d_md_div = mdiv;
    d_md_use = muse;
    #1;
  endtask

  task automatic holdCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic runMd(input logic div, input int lat, input string tag);
    int st_cnt;
    int busy_cnt;
    applyStimulus(1, 9, 10, 1, 1, 0, 0, 1, div, 1);
    checkOutput({tag, " start stall"}, int'(stall), 0);
    applyStimulus(1, 0, 0, 0, 0, 11, 1, 0, 0, 1);
    st_cnt = 0;
    busy_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (!stall) break;
      st_cnt++;
      if (md_busy) busy_cnt++;
      holdCycle();
    end
    checkOutput({tag, " stall cycles"}, st_cnt, MD_EN ? lat + 1 : 0);
    checkOutput({tag, " busy cycles"}, busy_cnt, MD_EN ? lat : 0);
    drain();
  endtask

  initial begin
    #2;
    checkOutput("reset stall", int'(stall), 0);
    checkOutput("reset md_busy", int'(md_busy), 0);
    checkOutput("reset selects", int'({fwd_d_sel, fwd_e_sel, fwd_m_sel}), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Load-use: lw $1 (tnew 2), then add $2,$1 with tuse 1.
    applyStimulus(1, 5, 0, 1, 0, 1, 2, 0, 0, 0);
    checkOutput("lw issue stall", int'(stall), 0);
    applyStimulus(1, 1, 6, 1, 1, 2, 1, 0, 0, 0);
    checkOutput("load-use stall", int'(stall), 1);
    checkOutput("load-use dsel0 stalled", selOf(fwd_d_sel, 0), 0);
    holdCycle();
    checkOutput("load-use release stall", int'(stall), 0);
    checkOutput("load-use release dsel0", selOf(fwd_d_sel, 0), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("load-use esel0", selOf(fwd_e_sel, 0), 3);
    checkOutput("load-use esel1", selOf(fwd_e_sel, 1), 0);
    drain();

    // Branch after ALU: add $3 (tnew 1), then beq $3 with tuse 0.
    applyStimulus(1, 7, 8, 1, 1, 3, 1, 0, 0, 0);
    checkOutput("alu issue stall", int'(stall), 0);
    applyStimulus(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("branch stall", int'(stall), 1);
    holdCycle();
    checkOutput("branch release stall", int'(stall), 0);
    checkOutput("branch dsel0", selOf(fwd_d_sel, 0), 2);
    drain();

    // Priority: $4 in slots 1 and 2 with tnew 0, so the nearest one wins.
    applyStimulus(1, 0, 0, 0, 0, 4, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 4, 0, 0, 0, 0);
    applyStimulus(1, 4, 0, 0, 0, 12, 1, 0, 0, 0);
    checkOutput("priority dsel0", selOf(fwd_d_sel, 0), 1);
    checkOutput("priority stall", int'(stall), 0);
    drain();

    // Priority: a nearer busy producer blocks the older ready one.
    applyStimulus(1, 0, 0, 0, 0, 4, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    applyStimulus(1, 4, 0, 0, 0, 12, 1, 0, 0, 0);
    checkOutput("blocked stall", int'(stall), 1);
    checkOutput("blocked dsel0", selOf(fwd_d_sel, 0), 0);
    holdCycle();
    checkOutput("blocked release dsel0", selOf(fwd_d_sel, 0), 2);
    drain();

    // $0 never forwards and never stalls.
    applyStimulus(1, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 13, 1, 0, 0, 0);
    checkOutput("zero-reg stall", int'(stall), 0);
    checkOutput("zero-reg selects", int'({fwd_d_sel, fwd_e_sel, fwd_m_sel}), 0);
    drain();

    // Multiply then mfhi, and divide then mfhi.
    runMd(1'b0, MULT_LAT, "mult");
    runMd(1'b1, DIV_LAT, "div");

    // Reset in the middle of a stall.
    applyStimulus(1, 9, 10, 1, 1, 0, 0, 1, 0, 1);
    applyStimulus(1, 5, 0, 1, 0, 1, 2, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 14, 1, 0, 0, 1);
    checkOutput("pre-reset stall", int'(stall), 1);
    checkOutput("pre-reset md_busy", int'(md_busy), int'(MD_EN));
    #1 reset_n = 1'b0;
    #1;
    checkOutput("mid-reset stall", int'(stall), 0);
    checkOutput("mid-reset md_busy", int'(md_busy), 0);
    checkOutput("mid-reset selects", int'({fwd_d_sel, fwd_e_sel, fwd_m_sel}), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    applyStimulus(1, 1, 1, 0, 0, 15, 1, 0, 0, 0);
    checkOutput("post-reset stall", int'(stall), 0);
    checkOutput("post-reset selects", int'({fwd_d_sel, fwd_e_sel, fwd_m_sel}), 0);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
